// File: rtl/mpd_io_cfg_loader.sv
// Serial loader for per-pad fabric configuration words. Each 12-bit word carries one odd-parity bit.
// The staged words reach fabric_config only after the whole frame has passed its parity checks.
module mpd_io_cfg_loader #(
  parameter int NUM_IO = 38,
  parameter int CFG_W  = 12
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    cfg_start,
  input  logic                    cfg_strobe,
  input  logic                    cfg_bit,
  output logic [NUM_IO*CFG_W-1:0] fabric_config,
  output logic                    fabric_done,
  output logic                    cfg_busy,
  output logic                    cfg_error
);

  localparam int WC_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_IO - 1);
  localparam logic [3:0]      PAR_SLOT  = 4'(CFG_W);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ERROR} state_t;

  state_t                    state_reg, state_next;
  logic [3:0]                bit_cnt_reg;
  logic [WC_W-1:0]           word_cnt_reg;
  logic                      parity_reg;
  logic [CFG_W-1:0]          stage_reg [NUM_IO];
  logic [NUM_IO*CFG_W-1:0]   stage_flat;

  logic load_strobe, parity_slot, parity_good, last_word, commit_en;

  // A start pulse in the same cycle as a strobe discards that strobe.
  assign load_strobe = (state_reg == LOAD) && cfg_strobe && !cfg_start;
  assign parity_slot = (bit_cnt_reg == PAR_SLOT);
  assign parity_good = parity_reg ^ cfg_bit;
  assign last_word   = (word_cnt_reg == LAST_WORD);
  assign commit_en   = (state_reg == COMMIT) && !cfg_start;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (cfg_start) begin
      state_next = LOAD;
    end else begin
      case (state_reg)
        LOAD: begin
          if (load_strobe && parity_slot) begin
            if (!parity_good)   state_next = ERROR;
            else if (last_word) state_next = COMMIT;
          end
        end
        COMMIT:  state_next = IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    cfg_busy  = (state_reg == LOAD) || (state_reg == COMMIT);
    cfg_error = (state_reg == ERROR);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      parity_reg   <= 1'b0;
    end else if (cfg_start) begin
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      parity_reg   <= 1'b0;
    end else if (load_strobe) begin
      if (!parity_slot) begin
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
        parity_reg  <= parity_reg ^ cfg_bit;
      end else begin
        bit_cnt_reg <= '0;
        parity_reg  <= 1'b0;
        if (parity_good && !last_word) word_cnt_reg <= word_cnt_reg + WC_W'(1);
      end
    end
  end

  // Each word shifts MSB first, so a complete word fully overwrites leftovers of an aborted frame.
  for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_stage
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        stage_reg[gi] <= '0;
      end else if (load_strobe && !parity_slot && (word_cnt_reg == WC_W'(gi))) begin
        stage_reg[gi] <= {stage_reg[gi][CFG_W-2:0], cfg_bit};
      end
    end
    assign stage_flat[gi*CFG_W +: CFG_W] = stage_reg[gi];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      fabric_config <= '0;
      fabric_done   <= 1'b0;
    end else if (cfg_start) begin
      fabric_done   <= 1'b0;
    end else if (commit_en) begin
      fabric_config <= stage_flat;
      fabric_done   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mpd_io_cfg_loader.sv
// Randomized scoreboard bench for mpd_io_cfg_loader: frames are modelled as word arrays,
// and a monitor checks every commit or error event against the queued expectation.
module tb_mpd_io_cfg_loader;

  localparam int NUM_IO = 38;
  localparam int CW     = NUM_IO * 12;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_strobe = 1'b0;
  logic          cfg_bit = 1'b0;
  logic [CW-1:0] fabric_config;
  logic          fabric_done, cfg_busy, cfg_error;

  mpd_io_cfg_loader #(.NUM_IO(NUM_IO), .CFG_W(12)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cfg_start(cfg_start),
    .cfg_strobe(cfg_strobe), .cfg_bit(cfg_bit), .fabric_config(fabric_config),
    .fabric_done(fabric_done), .cfg_busy(cfg_busy), .cfg_error(cfg_error)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [CW-1:0] cfg;
    logic          done;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            drive_cyc = 0;
  logic          busy_chk = 1'b0;
  logic [11:0]   frame_w [NUM_IO];
  logic [CW-1:0] model_committed = '0;
  logic          prev_done = 1'b0;
  logic          prev_err = 1'b0;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack_frame();
    logic [CW-1:0] v = '0;
    for (int i = 0; i < NUM_IO; i++) v[i*12 +: 12] = frame_w[i];
    return v;
  endfunction

  // Monitor: each rising fabric_done or cfg_error is one DUT response.
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      prev_done <= 1'b0;
      prev_err  <= 1'b0;
    end else begin
      if ((fabric_done && !prev_done) || (cfg_error && !prev_err)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {fabric_done, cfg_error}, '0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("event_config", fabric_config, e.cfg);
          chk("event_done", CW'(fabric_done), CW'(e.done));
          chk("event_error", CW'(cfg_error), CW'(e.err));
          chk("event_cycle", CW'(cyc), CW'(e.cyc));
        end
      end
      prev_done <= fabric_done;
      prev_err  <= cfg_error;
    end
  end

  task automatic drive(input logic st, input logic sb, input logic b);
    @(negedge wb_clk_i);
    if (busy_chk) chk("busy_in_frame", CW'(cfg_busy), CW'(1));
    cfg_start  = st;
    cfg_strobe = sb;
    cfg_bit    = b;
    drive_cyc  = cyc;
  endtask

  task automatic gap(input int maxgap);
    repeat ($urandom_range(0, maxgap)) drive(1'b0, 1'b0, 1'($urandom));
  endtask

  // Sends frame_w; bad_idx >= 0 flips that word's parity bit and ends the frame there.
  task automatic send_frame(input int bad_idx, input int maxgap, input logic strobe_with_start);
    logic par;
    exp_t e;
    drive(1'b1, strobe_with_start, strobe_with_start);
    busy_chk = 1'b1;
    for (int w = 0; w < NUM_IO; w++) begin
      for (int i = 11; i >= 0; i--) begin
        gap(maxgap);
        drive(1'b0, 1'b1, frame_w[w][i]);
      end
      gap(maxgap);
      par = ~(^frame_w[w]);
      if (w == bad_idx) par = ~par;
      drive(1'b0, 1'b1, par);
      if (w == bad_idx) begin
        e.cfg = model_committed; e.done = 1'b0; e.err = 1'b1; e.cyc = drive_cyc + 1;
        exp_q.push_back(e);
        busy_chk = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        return;
      end
    end
    model_committed = pack_frame();
    e.cfg = model_committed; e.done = 1'b1; e.err = 1'b0; e.cyc = drive_cyc + 2;
    exp_q.push_back(e);
    drive(1'b0, 1'b0, 1'b0);
    busy_chk = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill_frame(input logic [11:0] w0, input logic [11:0] w1, input logic rnd);
    for (int i = 0; i < NUM_IO; i++) frame_w[i] = rnd ? 12'($urandom) : 12'h000;
    frame_w[0] = w0;
    frame_w[1] = w1;
  endtask

  initial begin
    #(40000 * 10);
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 40000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge wb_clk_i);
    chk("reset_config", fabric_config, '0);
    chk("reset_done", CW'(fabric_done), '0);
    chk("reset_busy", CW'(cfg_busy), '0);
    chk("reset_error", CW'(cfg_error), '0);
    wb_rst_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    chk("idle_config", fabric_config, '0);
    chk("idle_busy", CW'(cfg_busy), '0);

    // Single good frame: 0x1FF then 0x800
    fill_frame(12'h1FF, 12'h800, 1'b0);
    send_frame(-1, 0, 1'b0);
    chk("good_low24", CW'(fabric_config[23:0]), CW'(24'h8001FF));

    // Parity error on word 1; committed value must survive, later strobes ignored
    send_frame(1, 0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'($urandom));
    drive(1'b0, 1'b0, 1'b0);
    chk("err_held", CW'(cfg_error), CW'(1));
    chk("err_done", CW'(fabric_done), '0);
    chk("err_busy", CW'(cfg_busy), '0);
    chk("err_config", fabric_config, model_committed);

    // Restart after 7 bits of word 0
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'($urandom));
    fill_frame(12'h0AA, 12'h555, 1'b0);
    send_frame(-1, 0, 1'b0);

    // Start and strobe in the same cycle: that bit must be discarded
    fill_frame(12'($urandom), 12'($urandom), 1'b1);
    send_frame(-1, 0, 1'b1);

    // Asynchronous reset in the middle of a frame
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'($urandom));
    #2 wb_rst_i = 1'b1;
    #1;
    chk("arst_config", fabric_config, '0);
    chk("arst_done", CW'(fabric_done), '0);
    chk("arst_busy", CW'(cfg_busy), '0);
    chk("arst_error", CW'(cfg_error), '0);
    model_committed = '0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int i = 0; i < 13 * 2; i++) drive(1'b0, 1'b1, 1'($urandom));
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("post_rst_done", CW'(fabric_done), '0);
    chk("post_rst_busy", CW'(cfg_busy), '0);
    chk("post_rst_config", fabric_config, '0);

    // Sparse random frames, including one with a random bad word
    for (int f = 0; f < 3; f++) begin
      fill_frame(12'($urandom), 12'($urandom), 1'b1);
      send_frame(-1, 5, 1'b0);
    end
    fill_frame(12'($urandom), 12'($urandom), 1'b1);
    send_frame(int'($urandom_range(0, NUM_IO - 1)), 2, 1'b0);
    fill_frame(12'($urandom), 12'($urandom), 1'b1);
    send_frame(-1, 3, 1'b0);

    repeat (4) drive(1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", CW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
